// File: rtl/mac_requant.sv
// Requantizer behind the MAC accumulator: round-to-nearest (ties toward +inf), then saturate.
// Two-stage valid/ready pipeline at full throughput, with a sticky saturation flag and counter.
module mac_requant #(
  parameter int unsigned int_in_p      = 9,
  parameter int unsigned frac_in_p     = 22,
  parameter int unsigned int_out_p     = 2,
  parameter int unsigned frac_out_p    = 11,
  parameter int unsigned count_width_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [int_in_p+frac_in_p-1:0]      data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [int_out_p+frac_out_p-1:0]    data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  input  logic                               clear_i,
  output logic                               sat_o,
  output logic [count_width_p-1:0]           sat_count_o
);

  localparam int unsigned InW   = int_in_p + frac_in_p;
  localparam int unsigned OutW  = int_out_p + frac_out_p;
  localparam int unsigned Shift = frac_in_p - frac_out_p;
  // Rounded value keeps the extra headroom bit of the widened add.
  localparam int unsigned S1W   = InW + 1 - Shift;

  localparam logic [InW:0]    RoundHalf = (InW+1)'(1) << (Shift - 1);
  localparam logic [S1W-1:0]  SatMax = {{(S1W-OutW+1){1'b0}}, {(OutW-1){1'b1}}};
  localparam logic [S1W-1:0]  SatMin = {{(S1W-OutW+1){1'b1}}, {(OutW-1){1'b0}}};
  localparam logic [OutW-1:0] OutMax = {1'b0, {(OutW-1){1'b1}}};
  localparam logic [OutW-1:0] OutMin = {1'b1, {(OutW-1){1'b0}}};

  logic              v1_q, v1_d;
  logic [S1W-1:0]    s1_q, s1_d;
  logic              v2_q, v2_d;
  logic [OutW-1:0]   data_q, data_d;
  logic              sat_q, sat_d;
  logic [count_width_p-1:0] cnt_q, cnt_d;

  logic              advance;
  logic              load1;
  logic              in_fire;
  logic [InW:0]      round_sum;
  logic [S1W-1:0]    round_val;
  logic              unused_round_lsbs;
  logic              sat_hi;
  logic              sat_lo;
  logic              sat_evt;
  logic [OutW-1:0]   sat_val;

  // Stage 1: add half an output LSB, then arithmetic shift by taking the upper slice.
  assign round_sum         = {data_i[InW-1], data_i} + RoundHalf;
  assign round_val         = round_sum[InW:Shift];
  assign unused_round_lsbs = ^round_sum[Shift-1:0];

  // Stage 2: clamp to the output range.
  assign sat_hi  = $signed(s1_q) > $signed(SatMax);
  assign sat_lo  = $signed(s1_q) < $signed(SatMin);
  assign sat_evt = sat_hi | sat_lo;

  always_comb begin
    sat_val = s1_q[OutW-1:0];
    if (sat_hi) begin
      sat_val = OutMax;
    end else if (sat_lo) begin
      sat_val = OutMin;
    end
  end

  assign advance = !v2_q || ready_i;
  assign load1   = !v1_q || advance;
  assign ready_o = load1;
  assign in_fire = valid_i && ready_o;

  always_comb begin
    v1_d   = v1_q;
    s1_d   = s1_q;
    v2_d   = v2_q;
    data_d = data_q;
    sat_d  = sat_q;
    cnt_d  = cnt_q;

    if (load1) begin
      v1_d = in_fire;
      if (in_fire) begin
        s1_d = round_val;
      end
    end

    if (advance) begin
      v2_d = v1_q;
      if (v1_q) begin
        data_d = sat_val;
        if (sat_evt) begin
          sat_d = 1'b1;
          if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end

    // Clear takes priority over a same-cycle saturation event.
    if (clear_i) begin
      sat_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1_q   <= 1'b0;
      s1_q   <= '0;
      v2_q   <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      s1_q   <= s1_d;
      v2_q   <= v2_d;
      data_q <= data_d;
      sat_q  <= sat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = v2_q;
  assign sat_o       = sat_q;
  assign sat_count_o = cnt_q;

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant: directed scenarios plus randomized traffic
// compared against an integer-arithmetic model of round-then-saturate.
module tb_mac_requant;

  localparam int IW = 31;
  localparam int OW = 13;
  localparam int SH = 11;
  localparam int CW = 16;
  localparam longint Step = longint'(1) << SH;
  localparam longint Half = longint'(1) << (SH - 1);
  localparam longint OMax = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMin = -(longint'(1) << (OW - 1));
  localparam longint One  = longint'(1) << 22;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic [IW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [OW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          sat_o;
  logic [CW-1:0] sat_count_o;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] pend[$];
  logic [IW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];

  mac_requant dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .clear_i    (clear_i),
    .sat_o      (sat_o),
    .sat_count_o(sat_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [IW-1:0] fx(input longint v);
    return v[IW-1:0];
  endfunction

  // Round to nearest with ties toward +inf via floor division, then clamp.
  function automatic logic [OW-1:0] model(input logic [IW-1:0] d, output bit sat);
    longint x, n, q;
    x = longint'($signed(d));
    n = x + Half;
    if (n >= 0) q = n / Step;
    else        q = -((-n + Step - 1) / Step);
    sat = 1'b0;
    if (q > OMax) begin
      q = OMax; sat = 1'b1;
    end else if (q < OMin) begin
      q = OMin; sat = 1'b1;
    end
    return q[OW-1:0];
  endfunction

  // One clock of traffic: offer pend front, record transfers seen before the edge.
  task automatic step(input int vpct, input int rpct);
    valid_i = (pend.size() > 0) && ($urandom_range(99) < vpct);
    data_i  = (pend.size() > 0) ? pend[0] : '0;
    ready_i = $urandom_range(99) < rpct;
    @(negedge clk);
    if (valid_i && ready_o) begin
      exp_q.push_back(data_i);
      void'(pend.pop_front());
    end
    if (valid_o && ready_i) got_q.push_back(data_o);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) step(100, 100);
  endtask

  task automatic clear_all();
    pend.delete(); exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    if (sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_o); end
    if (sat_count_o !== '0) begin
      errors++; $display("FAIL reset_count got %0d want 0", sat_count_o);
    end
    reset_ni = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
  endtask

  task automatic test_unity();
    ready_i = 1'b1; valid_i = 1'b1; data_i = fx(One);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL unity_early got %b want 0", valid_o); end
    @(negedge clk);
    checks += 3;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL unity_valid got %b want 1", valid_o); end
    if (data_o !== 13'h0800) begin errors++; $display("FAIL unity_data got %h want 0800", data_o); end
    if (sat_o !== 1'b0) begin errors++; $display("FAIL unity_sat got %b want 0", sat_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    logic [OW-1:0] want[4];
    want[0] = 13'h0001; want[1] = 13'h0000; want[2] = 13'h1FFF; want[3] = 13'h0000;
    clear_all();
    pend.push_back(fx(64'sh400));
    pend.push_back(fx(-64'sh400));
    pend.push_back(fx(-64'sh401));
    pend.push_back(fx(64'sh3FF));
    repeat (4) step(100, 100);
    checks++;
    if (exp_q.size() != 4) begin
      errors++; $display("FAIL round_throughput got %0d accepted want 4", exp_q.size());
    end
    drain(4, 20);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL round_count got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want[i]) begin
        errors++; $display("FAIL round_%0d got %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_all();
    pend.push_back(fx(3 * One));
    pend.push_back(fx(-5 * One));
    pend.push_back(fx(-2 * One));
    drain(3, 20);
    checks += 6;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL sat_outcount got %0d want 3", got_q.size());
    end else begin
      if (got_q[0] !== 13'h0FFF) begin errors++; $display("FAIL sat_pos got %h want 0fff", got_q[0]); end
      if (got_q[1] !== 13'h1000) begin errors++; $display("FAIL sat_neg got %h want 1000", got_q[1]); end
      if (got_q[2] !== 13'h1000) begin errors++; $display("FAIL sat_min got %h want 1000", got_q[2]); end
    end
    if (sat_o !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", sat_o); end
    if (sat_count_o !== 16'd2) begin
      errors++; $display("FAIL sat_count got %0d want 2", sat_count_o);
    end
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    checks += 2;
    if (sat_o !== 1'b0) begin errors++; $display("FAIL clear_flag got %b want 0", sat_o); end
    if (sat_count_o !== '0) begin
      errors++; $display("FAIL clear_count got %0d want 0", sat_count_o);
    end
    // Saturating word reaches stage 2 on the same edge that clear is high.
    ready_i = 1'b1; valid_i = 1'b1; data_i = fx(3 * One);
    @(posedge clk); #1;
    valid_i = 1'b0; clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    checks += 3;
    if (sat_count_o !== '0) begin
      errors++; $display("FAIL clear_coincident_count got %0d want 0", sat_count_o);
    end
    if (sat_o !== 1'b0) begin
      errors++; $display("FAIL clear_coincident_flag got %b want 0", sat_o);
    end
    if (valid_o !== 1'b1 || data_o !== 13'h0FFF) begin
      errors++; $display("FAIL clear_coincident_data got %b/%h want 1/0fff", valid_o, data_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bit held_ok = 1'b0;
    logic [OW-1:0] held = '0;
    clear_all();
    for (int k = 0; k < 10; k++) pend.push_back(fx(longint'(k) * Step));
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1; data_i = pend[0]; ready_i = 1'b0;
      @(negedge clk);
      if (valid_i && ready_o) begin
        acc++; void'(pend.pop_front());
      end
      if (valid_o) begin
        if (!held_ok) begin
          held = data_o; held_ok = 1'b1;
        end else begin
          checks++;
          if (data_o !== held) begin
            errors++; $display("FAIL bp_stable got %h want %h", data_o, held);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks += 3;
    if (acc != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc); end
    if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", ready_o); end
    if (held !== 13'd0) begin errors++; $display("FAIL bp_head got %h want 0", held); end
    valid_i = 1'b0;
    drain(10, 60);
    checks++;
    if (got_q.size() != 10) begin
      errors++; $display("FAIL bp_outcount got %0d want 10", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== OW'(k)) begin
        errors++; $display("FAIL bp_order_%0d got %h want %h", k, got_q[k], OW'(k));
      end
    end
  endtask

  task automatic test_random();
    int clamps = 0;
    bit s;
    logic [OW-1:0] w;
    longint v;
    clear_all();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) begin
        pend.push_back(IW'($urandom));
      end else begin
        v = longint'($urandom_range(0, 10 * 4194304)) - 5 * One;
        if ($urandom_range(3) == 0) v = (v & ~(Step - 1)) | Half;
        pend.push_back(fx(v));
      end
    end
    for (int c = 0; c < 20000 && got_q.size() < 1000; c++) step(50, 50);
    repeat (4) step(0, 100);
    checks += 2;
    if (exp_q.size() != got_q.size()) begin
      errors++; $display("FAIL rand_xfer in %0d out %0d", exp_q.size(), got_q.size());
    end
    if (got_q.size() != 1000) begin
      errors++; $display("FAIL rand_outcount got %0d want 1000", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      w = model(exp_q[i], s);
      if (s) clamps++;
      checks++;
      if (got_q[i] !== w) begin
        errors++; $display("FAIL rand_word_%0d in %h got %h want %h", i, exp_q[i], got_q[i], w);
      end
    end
    checks++;
    if (sat_count_o !== CW'(clamps)) begin
      errors++; $display("FAIL rand_satcount got %0d want %0d", sat_count_o, clamps);
    end
  endtask

  task automatic test_reset_midflight();
    ready_i = 1'b0;
    repeat (2) begin
      valid_i = 1'b1; data_i = fx(3 * One);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    checks += 2;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", valid_o); end
    if (sat_count_o !== '0) begin
      errors++; $display("FAIL rst_mid_count got %0d want 0", sat_count_o);
    end
    #3 reset_ni = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = fx(One);
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got %b want 0", valid_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_early got %b want 0", valid_o); end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 13'h0800) begin
      errors++; $display("FAIL rst_mid_latency got %b/%h want 1/0800", valid_o, data_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
